// File: rtl/uart_tx_top.sv
// uart_tx_top
//   UART transmitter. Captures one 8-bit word in IDLE and sends it as
//   start(0), 8 data bits LSB first, optional even/odd parity bit, stop(1).
//   One bit is sent per clock cycle, so the clock is the bit clock.
//
//   Handshake: DATA_VALID_TOP is a request strobe. It is sampled only while
//   the FSM is in IDLE. A rising edge in IDLE with DATA_VALID_TOP=1 is the
//   capture edge for P_DATA_TOP, PAR_EN_TOP and PAR_TYP_TOP. Busy_TOP is high
//   from the start bit through the stop bit. The FSM always spends at least
//   one cycle in IDLE between frames. There is no ready output; the producer
//   waits for Busy_TOP to fall.
//
// Ports
//   CLK_TOP         in   bit clock, rising edge
//   RST_TOP         in   asynchronous, active-high reset
//   P_DATA_TOP      in   [7:0] word to transmit
//   DATA_VALID_TOP  in   transmit request, sampled in IDLE only
//   PAR_EN_TOP      in   1 = append a parity bit
//   PAR_TYP_TOP     in   0 = even parity, 1 = odd parity
//   TX_OUT_TOP      out  serial line, idles high
//   Busy_TOP        out  frame in progress
//   fsm_state_dbg   out  [2:0] current FSM state (IDLE=0 .. STOP=4)

module uart_tx_top (
    input  logic       CLK_TOP,
    input  logic       RST_TOP,
    input  logic [7:0] P_DATA_TOP,
    input  logic       DATA_VALID_TOP,
    input  logic       PAR_EN_TOP,
    input  logic       PAR_TYP_TOP,
    output logic       TX_OUT_TOP,
    output logic       Busy_TOP,
    output logic [2:0] fsm_state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       par_bit;
    logic       par_en_q;
    logic       load;

    assign load          = (state == IDLE) && DATA_VALID_TOP;
    assign fsm_state_dbg = state;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (DATA_VALID_TOP) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = DATA;
            end
            DATA: begin
                if (bit_cnt == 3'd7) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer: shift_reg[0] is always the bit on the line during DATA.
    // The counter is cleared on capture so DATA always starts at bit 0.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
        end else if (load) begin
            shift_reg <= P_DATA_TOP;
            bit_cnt   <= 3'd0;
        end else if (state == DATA) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Parity calculator: computed once from the word at capture, so later
    // changes on the inputs cannot disturb the frame in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP) begin
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else if (load) begin
            par_bit  <= (^P_DATA_TOP) ^ PAR_TYP_TOP;
            par_en_q <= PAR_EN_TOP;
        end
    end

    // ------------------------------------------------------------------
    // Output mux: decoded from registered state only, so reset drives the
    // line high and clears Busy without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        TX_OUT_TOP = 1'b1;
        Busy_TOP   = 1'b0;
        case (state)
            IDLE: begin
                TX_OUT_TOP = 1'b1;
                Busy_TOP   = 1'b0;
            end
            START: begin
                TX_OUT_TOP = 1'b0;
                Busy_TOP   = 1'b1;
            end
            DATA: begin
                TX_OUT_TOP = shift_reg[0];
                Busy_TOP   = 1'b1;
            end
            PARITY: begin
                TX_OUT_TOP = par_bit;
                Busy_TOP   = 1'b1;
            end
            STOP: begin
                TX_OUT_TOP = 1'b1;
                Busy_TOP   = 1'b1;
            end
            default: begin
                TX_OUT_TOP = 1'b1;
                Busy_TOP   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top
//   Directed bench for uart_tx_top. Each frame is described by a hand-written
//   line sequence, read left to right as the cycles after the capture edge:
//   start, data bits 0..7, [parity], stop, idle.

module tb_uart_tx_top;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;
    logic [2:0] fsm_state_dbg;

    int n_checks;
    int n_pass;

    logic exp_q[$];

    uart_tx_top dut (
        .CLK_TOP        (clk),
        .RST_TOP        (rst),
        .P_DATA_TOP     (p_data),
        .DATA_VALID_TOP (data_valid),
        .PAR_EN_TOP     (par_en),
        .PAR_TYP_TOP    (par_typ),
        .TX_OUT_TOP     (tx_out),
        .Busy_TOP       (busy),
        .fsm_state_dbg  (fsm_state_dbg)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver + scoreboard for one frame.
    //   exp_tx[k] : line level in cycle k after the capture edge (k=0 start)
    //   len       : frame length; cycle len is the idle cycle (busy=0)
    //   glitch_at : cycle after which a stray request with 0xFF is pulsed
    //   hold      : keep DATA_VALID high (back-to-back frames)
    // Called at a point where the DUT is in IDLE, away from the clock edge.
    // ------------------------------------------------------------------
    task automatic run_frame(input string name, input logic [7:0] data,
                             input logic pen, input logic ptyp,
                             input logic [0:11] exp_tx, input int len,
                             input int glitch_at, input bit hold);
        logic e;
        data_valid = 1'b1;
        p_data     = data;
        par_en     = pen;
        par_typ    = ptyp;
        for (int k = 0; k <= len; k++) begin
            exp_q.push_back(exp_tx[k]);
        end
        for (int k = 0; k <= len; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 && !hold) begin
                // Everything after the capture edge must be ignored.
                data_valid = 1'b0;
                p_data     = 8'hFF;
                par_en     = ~pen;
                par_typ    = ~ptyp;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s tx c%0d", name, k), {7'b0, tx_out}, {7'b0, e});
            chk($sformatf("%s busy c%0d", name, k), {7'b0, busy}, {7'b0, (k < len)});
            if (k == glitch_at) begin
                data_valid = 1'b1;
                p_data     = 8'hFF;
            end else if (glitch_at >= 0 && k == glitch_at + 1) begin
                data_valid = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset tx", {7'b0, tx_out}, 8'h01);
        chk("reset busy", {7'b0, busy}, 8'h00);
        chk("reset state", {5'b0, fsm_state_dbg}, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle tx", {7'b0, tx_out}, 8'h01);
        chk("idle busy", {7'b0, busy}, 8'h00);

        // 0x2A even parity: data 0,1,0,1,0,1,0,0  parity 1
        run_frame("f2a", 8'h2A, 1'b1, 1'b0, 12'b0_01010100_1_1_1, 11, -1, 1'b0);

        // 0x59 odd parity with a stray request around bit 3:
        // data 1,0,0,1,1,0,1,0  parity 1
        run_frame("f59", 8'h59, 1'b1, 1'b1, 12'b0_10011010_1_1_1, 11, 3, 1'b0);

        // 0x42 without parity: data 0,1,0,0,0,0,1,0, stop, idle
        run_frame("f42", 8'h42, 1'b0, 1'b0, 12'b0_01000010_1_1_1, 10, -1, 1'b0);

        // 0x55 even parity, request held: two frames, one idle cycle between
        // data 1,0,1,0,1,0,1,0  parity 0
        run_frame("b2b1", 8'h55, 1'b1, 1'b0, 12'b0_10101010_0_1_1, 11, -1, 1'b1);
        run_frame("b2b2", 8'h55, 1'b1, 1'b0, 12'b0_10101010_0_1_1, 11, -1, 1'b1);
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b after tx", {7'b0, tx_out}, 8'h01);
        chk("b2b after busy", {7'b0, busy}, 8'h00);

        // Reset in the middle of data bit 4 of 0x2A (bit 4 = 0)
        data_valid = 1'b1;
        p_data     = 8'h2A;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        chk("rst start tx", {7'b0, tx_out}, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("rst bit4 tx", {7'b0, tx_out}, 8'h00);
        chk("rst bit4 busy", {7'b0, busy}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async tx", {7'b0, tx_out}, 8'h01);
        chk("rst async busy", {7'b0, busy}, 8'h00);
        chk("rst async state", {5'b0, fsm_state_dbg}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst tx", {7'b0, tx_out}, 8'h01);
        chk("post rst busy", {7'b0, busy}, 8'h00);

        // Clean frame after reset: 0xA5 odd parity, data 1,0,1,0,0,1,0,1 parity 1
        run_frame("fa5", 8'hA5, 1'b1, 1'b1, 12'b0_10100101_1_1_1, 11, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
